// File: rtl/h2c_pkg.sv
// Shared types and helpers for the H2C slot writer: slot count, FSM states,
// the slot length type, keep popcount and saturating length accumulation.
package h2c_pkg;

  localparam int unsigned NUM_SLOTS = 8;

  typedef enum logic [1:0] {
    WAIT,
    FILL,
    DRAIN
  } state_e;

  typedef logic [15:0] slot_len_t;

  function automatic logic [3:0] popcount8(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + 4'(keep[i]);
    end
    return cnt;
  endfunction

  function automatic slot_len_t len_add_sat(input slot_len_t acc, input logic [4:0] add);
    logic [16:0] sum;
    sum = {1'b0, acc} + 17'(add);
    return sum[16] ? '1 : sum[15:0];
  endfunction

endpackage

// File: rtl/h2c_beat_packer.sv
// Packs 64-bit H2C beats into 128-bit words: even beat latches the low half,
// odd beat (or tlast on an even beat) presents a complete word with its byte count.
module h2c_beat_packer
  import h2c_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         beat_fire,
  input  logic [63:0]  beat_data,
  input  logic [7:0]   beat_keep,
  input  logic         beat_last,
  output logic         word_vld,
  output logic [127:0] word_data,
  output logic [4:0]   word_bytes
);

  logic        phase_q, phase_d;
  logic [63:0] lo_q, lo_d;
  logic [3:0]  lo_cnt_q, lo_cnt_d;
  logic [3:0]  beat_cnt;

  always_comb begin
    beat_cnt = popcount8(beat_keep);
    phase_d  = phase_q;
    lo_d     = lo_q;
    lo_cnt_d = lo_cnt_q;
    word_vld = beat_fire && (phase_q || beat_last);
    if (phase_q) begin
      word_data  = {beat_data, lo_q};
      word_bytes = 5'(lo_cnt_q) + 5'(beat_cnt);
    end else begin
      word_data  = {64'h0, beat_data};
      word_bytes = 5'(beat_cnt);
    end
    if (beat_fire) begin
      if (!phase_q) begin
        lo_d     = beat_data;
        lo_cnt_d = beat_cnt;
      end
      // tlast always returns the phase to even for the next packet
      phase_d = !phase_q && !beat_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= 1'b0;
      lo_q     <= '0;
      lo_cnt_q <= '0;
    end else begin
      phase_q  <= phase_d;
      lo_q     <= lo_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

endmodule

// File: rtl/h2c_slot_writer.sv
// Writes each H2C packet into one of 8 fixed-size inbound-RAM slots round-robin,
// publishing per-slot valid, length and overflow flags until the slot is released.
module h2c_slot_writer
  import h2c_pkg::*;
#(
  parameter int unsigned SLOT_WORDS = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [63:0]                  m_axis_h2c_tdata_0,
  input  logic [7:0]                   m_axis_h2c_tkeep_0,
  input  logic                         m_axis_h2c_tlast_0,
  input  logic                         m_axis_h2c_tvalid_0,
  output logic                         m_axis_h2c_tready_0,
  output logic [127:0]                 WrData,
  output logic                         WrEn,
  output logic [31:0]                  WrAddr,
  output logic [NUM_SLOTS-1:0]         SlotValid,
  input  logic [NUM_SLOTS-1:0]         SlotRelease,
  output logic [NUM_SLOTS-1:0][15:0]   SlotLen,
  output logic [NUM_SLOTS-1:0]         SlotOvf
);

  localparam int unsigned         IDX_W    = $clog2(SLOT_WORDS) + 1;
  localparam logic [IDX_W-1:0]    IDX_FULL = IDX_W'(SLOT_WORDS);

  state_e                       state_q, state_d;
  logic [2:0]                   cur_slot_q, cur_slot_d;
  logic [IDX_W-1:0]             word_idx_q, word_idx_d;
  slot_len_t                    len_q, len_d;
  logic                         wr_en_q, wr_en_d;
  logic [127:0]                 wr_data_q, wr_data_d;
  logic [31:0]                  wr_addr_q, wr_addr_d;
  logic [NUM_SLOTS-1:0]         slot_valid_q, slot_valid_d;
  logic [NUM_SLOTS-1:0]         slot_ovf_q, slot_ovf_d;
  logic [NUM_SLOTS-1:0][15:0]   slot_len_q, slot_len_d;

  logic         beat_fire;
  logic         word_vld;
  logic [127:0] word_data;
  logic [4:0]   word_bytes;
  logic         fin;
  logic         fin_ovf;
  slot_len_t    fin_len;

  assign m_axis_h2c_tready_0 = (state_q != WAIT);
  assign beat_fire           = m_axis_h2c_tvalid_0 && (state_q == FILL);

  h2c_beat_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_fire  (beat_fire),
    .beat_data  (m_axis_h2c_tdata_0),
    .beat_keep  (m_axis_h2c_tkeep_0),
    .beat_last  (m_axis_h2c_tlast_0),
    .word_vld   (word_vld),
    .word_data  (word_data),
    .word_bytes (word_bytes)
  );

  always_comb begin
    state_d      = state_q;
    cur_slot_d   = cur_slot_q;
    word_idx_d   = word_idx_q;
    len_d        = len_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    slot_valid_d = slot_valid_q;
    slot_ovf_d   = slot_ovf_q;
    slot_len_d   = slot_len_q;
    fin          = 1'b0;
    fin_ovf      = 1'b0;
    fin_len      = len_q;

    for (int unsigned n = 0; n < NUM_SLOTS; n++) begin
      if (SlotRelease[n] && slot_valid_q[n]) begin
        slot_valid_d[n] = 1'b0;
        slot_ovf_d[n]   = 1'b0;
        slot_len_d[n]   = '0;
      end
    end

    case (state_q)
      WAIT: begin
        if (!slot_valid_q[cur_slot_q]) state_d = FILL;
      end
      FILL: begin
        if (word_vld) begin
          if (word_idx_q == IDX_FULL) begin
            // slot full: a tlast here completes at once, otherwise discard the rest
            if (m_axis_h2c_tlast_0) begin
              fin     = 1'b1;
              fin_ovf = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            wr_en_d    = 1'b1;
            wr_data_d  = word_data;
            wr_addr_d  = BASE_ADDR + 32'(cur_slot_q) * SLOT_WORDS + 32'(word_idx_q);
            word_idx_d = word_idx_q + IDX_W'(1);
            len_d      = len_add_sat(len_q, word_bytes);
            if (m_axis_h2c_tlast_0) begin
              fin     = 1'b1;
              fin_len = len_d;
            end
          end
        end
      end
      DRAIN: begin
        if (m_axis_h2c_tvalid_0 && m_axis_h2c_tlast_0) begin
          fin     = 1'b1;
          fin_ovf = 1'b1;
        end
      end
      default: state_d = WAIT;
    endcase

    if (fin) begin
      slot_valid_d[cur_slot_q] = 1'b1;
      slot_ovf_d[cur_slot_q]   = fin_ovf;
      slot_len_d[cur_slot_q]   = fin_len;
      cur_slot_d               = cur_slot_q + 3'd1;
      word_idx_d               = '0;
      len_d                    = '0;
      state_d                  = WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT;
      cur_slot_q   <= '0;
      word_idx_q   <= '0;
      len_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= BASE_ADDR;
      slot_valid_q <= '0;
      slot_ovf_q   <= '0;
      slot_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_slot_q   <= cur_slot_d;
      word_idx_q   <= word_idx_d;
      len_q        <= len_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      slot_valid_q <= slot_valid_d;
      slot_ovf_q   <= slot_ovf_d;
      slot_len_q   <= slot_len_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign WrData    = wr_data_q;
  assign WrAddr    = wr_addr_q;
  assign SlotValid = slot_valid_q;
  assign SlotOvf   = slot_ovf_q;
  assign SlotLen   = slot_len_q;

endmodule

// File: tb/tb_h2c_slot_writer.sv
// Scoreboard bench for h2c_slot_writer: expected RAM writes are queued as stimulus
// is issued and a monitor checks each WrEn; slot flags are checked directly.
module tb_h2c_slot_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [63:0]       a_td, b_td;
  logic [7:0]        a_tk, b_tk;
  logic              a_tl, b_tl, a_tv, b_tv, a_tr, b_tr;
  logic [127:0]      a_wd, b_wd;
  logic              a_we, b_we;
  logic [31:0]       a_wa, b_wa;
  logic [7:0]        a_sv, b_sv, a_rel, b_rel, a_so, b_so;
  logic [7:0][15:0]  a_sl, b_sl;

  h2c_slot_writer #(.SLOT_WORDS(64), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m_axis_h2c_tdata_0(a_td), .m_axis_h2c_tkeep_0(a_tk), .m_axis_h2c_tlast_0(a_tl),
    .m_axis_h2c_tvalid_0(a_tv), .m_axis_h2c_tready_0(a_tr),
    .WrData(a_wd), .WrEn(a_we), .WrAddr(a_wa),
    .SlotValid(a_sv), .SlotRelease(a_rel), .SlotLen(a_sl), .SlotOvf(a_so)
  );

  h2c_slot_writer #(.SLOT_WORDS(4), .BASE_ADDR(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m_axis_h2c_tdata_0(b_td), .m_axis_h2c_tkeep_0(b_tk), .m_axis_h2c_tlast_0(b_tl),
    .m_axis_h2c_tvalid_0(b_tv), .m_axis_h2c_tready_0(b_tr),
    .WrData(b_wd), .WrEn(b_we), .WrAddr(b_wa),
    .SlotValid(b_sv), .SlotRelease(b_rel), .SlotLen(b_sl), .SlotOvf(b_so)
  );

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  int  vecs = 0;
  int  errs = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_a(input logic [31:0] addr, input logic [127:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] addr, input logic [127:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_b.push_back(e);
  endtask

  // monitor: every write strobe must match the head of its queue
  initial begin
    forever begin
      @(negedge clk);
      if (a_we === 1'b1) begin
        if (exp_a.size() == 0) begin
          vecs++; errs++;
          $display("FAIL a_unexpected_write: addr %0h data %0h, required no write", a_wa, a_wd);
        end else begin
          wr_t e;
          e = exp_a.pop_front();
          chk("a_wr_addr", 128'(a_wa), 128'(e.addr));
          chk("a_wr_data", a_wd, e.data);
        end
      end
      if (b_we === 1'b1) begin
        if (exp_b.size() == 0) begin
          vecs++; errs++;
          $display("FAIL b_unexpected_write: addr %0h data %0h, required no write", b_wa, b_wd);
        end else begin
          wr_t e;
          e = exp_b.pop_front();
          chk("b_wr_addr", 128'(b_wa), 128'(e.addr));
          chk("b_wr_data", b_wd, e.data);
        end
      end
    end
  end

  task automatic beat_a(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [7:0] rel);
    int n = 0;
    a_td = d; a_tk = k; a_tl = l; a_tv = 1'b1;
    while (a_tr !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vecs++; errs++;
      $display("FAIL a_tready_timeout: tready %b, required 1", a_tr);
    end
    a_rel = rel;
    @(negedge clk);
    a_tv = 1'b0; a_rel = '0;
  endtask

  task automatic beat_b(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    b_td = d; b_tk = k; b_tl = l; b_tv = 1'b1;
    while (b_tr !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vecs++; errs++;
      $display("FAIL b_tready_timeout: tready %b, required 1", b_tr);
    end
    @(negedge clk);
    b_tv = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_tready"}, 128'(a_tr), 128'(0));
    chk({tag, "_wren"}, 128'(a_we), 128'(0));
    chk({tag, "_wrdata"}, a_wd, 128'(0));
    chk({tag, "_wraddr"}, 128'(a_wa), 128'(0));
    chk({tag, "_valid"}, 128'(a_sv), 128'(0));
    chk({tag, "_ovf"}, 128'(a_so), 128'(0));
    chk({tag, "_len"}, 128'(a_sl), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic blocked;
    rst_n = 1'b0;
    a_td = '0; a_tk = '0; a_tl = 1'b0; a_tv = 1'b0; a_rel = '0;
    b_td = '0; b_tk = '0; b_tl = 1'b0; b_tv = 1'b0; b_rel = '0;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    chk("reset_b_valid", 128'(b_sv), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 4 full beats into slot 0
    push_a(32'd0, {64'h1111_0000_0000_0001, 64'h1111_0000_0000_0000});
    push_a(32'd1, {64'h1111_0000_0000_0003, 64'h1111_0000_0000_0002});
    beat_a(64'h1111_0000_0000_0000, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h1111_0000_0000_0001, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h1111_0000_0000_0002, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h1111_0000_0000_0003, 8'hFF, 1'b1, 8'h00);
    chk("p1_valid", 128'(a_sv), 128'(8'h01));
    chk("p1_len0", 128'(a_sl[0]), 128'(32));
    chk("p1_ovf", 128'(a_so), 128'(0));

    // 3 beats, last half word, into slot 1
    push_a(32'd64, {64'h2222_0000_0000_0001, 64'h2222_0000_0000_0000});
    push_a(32'd65, {64'h0, 64'h0000_0000_CAFE_F00D});
    beat_a(64'h2222_0000_0000_0000, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h2222_0000_0000_0001, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h0000_0000_CAFE_F00D, 8'h0F, 1'b1, 8'h00);
    chk("p2_valid", 128'(a_sv), 128'(8'h03));
    chk("p2_len1", 128'(a_sl[1]), 128'(20));

    // reset after 3 beats of a packet into slot 2
    push_a(32'd128, {64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000});
    beat_a(64'h3333_0000_0000_0000, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h3333_0000_0000_0001, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h3333_0000_0000_0002, 8'hFF, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk_reset_a("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1-beat packets fill all slots from BASE_ADDR
    for (int unsigned k = 0; k < 8; k++) begin
      push_a(32'(k * 64), {64'h0, 64'h9000_0000_0000_0000 | 64'(k)});
      beat_a(64'h9000_0000_0000_0000 | 64'(k), 8'hFF, 1'b1, 8'h00);
    end
    chk("fill_valid", 128'(a_sv), 128'(8'hFF));
    for (int unsigned k = 0; k < 8; k++) chk("fill_len", 128'(a_sl[k]), 128'(8));

    // ninth packet blocks until slot 0 is released
    a_td = 64'h9000_0000_0000_0008; a_tk = 8'hFF; a_tl = 1'b1; a_tv = 1'b1;
    blocked = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (a_tr !== 1'b0) blocked = 1'b1;
    end
    chk("ninth_tready_low", 128'(blocked), 128'(0));
    push_a(32'd0, {64'h0, 64'h9000_0000_0000_0008});
    a_rel = 8'h01;
    @(negedge clk);
    a_rel = '0;
    beat_a(64'h9000_0000_0000_0008, 8'hFF, 1'b1, 8'h00);
    chk("ninth_valid", 128'(a_sv), 128'(8'hFF));

    // release slots 1 and 5, then 5 again while not valid
    a_rel = 8'h22;
    @(negedge clk);
    a_rel = '0;
    chk("rel_valid", 128'(a_sv), 128'(8'hDD));
    chk("rel_len5", 128'(a_sl[5]), 128'(0));
    a_rel = 8'h20;
    @(negedge clk);
    a_rel = '0;
    @(negedge clk);
    chk("rel_nonvalid", 128'(a_sv), 128'(8'hDD));
    chk("rel_len4", 128'(a_sl[4]), 128'(8));

    // slot 1 completes while slot 2 is released
    push_a(32'd64, {64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000});
    beat_a(64'h4444_0000_0000_0000, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h4444_0000_0000_0001, 8'hFF, 1'b1, 8'h04);
    chk("cross_valid", 128'(a_sv), 128'(8'hDB));
    chk("cross_len1", 128'(a_sl[1]), 128'(16));
    chk("cross_len2", 128'(a_sl[2]), 128'(0));

    // zero-keep last beat into slot 2
    push_a(32'd128, {64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000});
    beat_a(64'h5555_0000_0000_0000, 8'hFF, 1'b0, 8'h00);
    beat_a(64'h5555_0000_0000_0001, 8'h00, 1'b1, 8'h00);
    chk("zkeep_valid", 128'(a_sv), 128'(8'hDF));
    chk("zkeep_len2", 128'(a_sl[2]), 128'(8));
    chk("zkeep_ovf", 128'(a_so), 128'(0));

    // 4-word slots: 12 beats overflow after 8
    for (int unsigned w = 0; w < 4; w++) begin
      push_b(32'(w), {64'hB000_0000_0000_0000 | 64'(2 * w + 1),
                      64'hB000_0000_0000_0000 | 64'(2 * w)});
    end
    for (int unsigned i = 0; i < 12; i++) begin
      beat_b(64'hB000_0000_0000_0000 | 64'(i), 8'hFF, (i == 11));
    end
    chk("ovf_valid", 128'(b_sv), 128'(8'h01));
    chk("ovf_flag", 128'(b_so), 128'(8'h01));
    chk("ovf_len0", 128'(b_sl[0]), 128'(64));

    repeat (4) @(negedge clk);
    chk("a_pending_writes", 128'(exp_a.size()), 128'(0));
    chk("b_pending_writes", 128'(exp_b.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
